// File: rtl/fpu_vector_driver_pkg.sv
// Shared constants and types for the fpu100_mul vector driver.
// Field layout of testVector/resultVector plus the driver FSM state encoding.
// No logic; imported by the interface, driver and bench.
package fpu_vec_pkg;

    // Vector widths and control-bit positions on the circuit side.
    localparam int TV_W      = 70;
    localparam int RV_W      = 41;
    localparam int START_BIT = 69;
    localparam int READY_BIT = 32;

    // testVector operand fields.
    localparam int OPA_LSB   = 0;
    localparam int OPA_W     = 32;
    localparam int OPB_LSB   = 32;
    localparam int OPB_W     = 32;
    localparam int OP_LSB    = 64;
    localparam int OP_W      = 3;
    localparam int RMODE_LSB = 67;
    localparam int RMODE_W   = 2;

    // resultVector fields: result word below READY, status flags above it.
    localparam int RES_LSB   = 0;
    localparam int RES_W     = 32;
    localparam int FLAGS_LSB = 33;
    localparam int FLAGS_W   = 8;

    // Default driver parameters.
    localparam int TIMEOUT_DEF = 64;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_HOLD
    } drv_state_e;

    // Assemble a stimulus word; START is always left clear.
    function automatic logic [TV_W-1:0] pack_vec(
        input logic [OPA_W-1:0]   opa,
        input logic [OPB_W-1:0]   opb,
        input logic [OP_W-1:0]    op,
        input logic [RMODE_W-1:0] rmode
    );
        logic [TV_W-1:0] v;
        v = '0;
        v[OPA_LSB   +: OPA_W]   = opa;
        v[OPB_LSB   +: OPB_W]   = opb;
        v[OP_LSB    +: OP_W]    = op;
        v[RMODE_LSB +: RMODE_W] = rmode;
        return v;
    endfunction

endpackage

// File: rtl/fpu_vector_driver_if.sv
// Stimulus-in / result-out streams of the vector driver.
// No latency of its own; wires only.
// Both streams use valid/ready; a beat moves when both are high on a rising edge.
interface fpu_vector_driver_if;
    import fpu_vec_pkg::*;

    logic [TV_W-1:0] vec_data;
    logic            vec_valid;
    logic            vec_ready;

    logic [RV_W-1:0] res_data;
    logic            res_timeout;
    logic            res_valid;
    logic            res_ready;

    // Master: stimulus producer and result consumer (FIFO side).
    modport master (
        output vec_data, vec_valid, res_ready,
        input  vec_ready, res_data, res_timeout, res_valid
    );

    // Slave: the driver itself.
    modport slave (
        input  vec_data, vec_valid, res_ready,
        output vec_ready, res_data, res_timeout, res_valid
    );

endinterface

// File: rtl/fpu_vector_driver_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
// Count visible one cycle after inc.
// No backpressure; inc is a single-cycle strobe.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority, increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fpu_vector_driver.sv
// Drives one stimulus onto a circuit's testVector, pulses START, captures resultVector on READY edge or timeout.
// Accept at N -> START at N+1 -> res_valid at N+2+k (k = WAIT cycles until READY rises).
// Accepts stimulus only in IDLE; result is held until res_ready, blocking new stimulus.
module fpu_vector_driver
    import fpu_vec_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    fpu_vector_driver_if.slave   vec_if,
    output logic [TV_W-1:0]      test_vector,
    input  logic [RV_W-1:0]      result_vector,
    output logic                 busy,
    output logic [CNT_W-1:0]     ops_done,
    output logic [CNT_W-1:0]     timeouts
);

    localparam int              WCNT_W    = $clog2(TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    drv_state_e        state_q,    state_d;
    logic [TV_W-1:0]   tv_q,       tv_d;
    logic [RV_W-1:0]   res_data_q, res_data_d;
    logic              res_to_q,   res_to_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              rdy_prev_q, rdy_prev_d;

    logic vec_ready_int;
    logic accept;
    logic done;
    logic ops_inc;
    logic to_inc;

    assign vec_ready_int = (state_q == S_IDLE) && !rst;
    assign accept        = vec_if.vec_valid && vec_ready_int;

    // READY is registered every cycle so a level left high by a previous op never counts as completion.
    assign rdy_prev_d = result_vector[READY_BIT];
    assign done       = result_vector[READY_BIT] && !rdy_prev_q;

    // Next-state, operand latch, result capture and counter strobes.
    always_comb begin
        state_d    = state_q;
        tv_d       = tv_q;
        res_data_d = res_data_q;
        res_to_d   = res_to_q;
        wait_cnt_d = wait_cnt_q;
        ops_inc    = 1'b0;
        to_inc     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tv_d            = vec_if.vec_data;
                    tv_d[START_BIT] = 1'b0;
                    state_d         = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                // A READY edge on the last allowed cycle still counts as a completion.
                if (done) begin
                    res_data_d = result_vector;
                    res_to_d   = 1'b0;
                    ops_inc    = 1'b1;
                    state_d    = S_HOLD;
                end else if (wait_cnt_q == WCNT_LAST) begin
                    res_data_d = result_vector;
                    res_to_d   = 1'b1;
                    to_inc     = 1'b1;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (vec_if.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, operand, result and edge-detect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tv_q       <= '0;
            res_data_q <= '0;
            res_to_q   <= 1'b0;
            wait_cnt_q <= '0;
            rdy_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tv_q       <= tv_d;
            res_data_q <= res_data_d;
            res_to_q   <= res_to_d;
            wait_cnt_q <= wait_cnt_d;
            rdy_prev_q <= rdy_prev_d;
        end
    end

    // Operands come straight from the latch; START is raised only while in LAUNCH.
    always_comb begin
        test_vector            = tv_q;
        test_vector[START_BIT] = (state_q == S_LAUNCH);
    end

    assign vec_if.vec_ready   = vec_ready_int;
    assign vec_if.res_valid   = (state_q == S_HOLD);
    assign vec_if.res_data    = res_data_q;
    assign vec_if.res_timeout = res_to_q;
    assign busy               = (state_q != S_IDLE);

    sat_counter #(.CNT_W(CNT_W)) u_ops_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (ops_inc),
        .cnt (ops_done)
    );

    sat_counter #(.CNT_W(CNT_W)) u_to_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (to_inc),
        .cnt (timeouts)
    );

endmodule
